// File: rtl/pc_3gpp_llr_map.sv
// Soft demapper and LLR buffer for the polar SC decoder.
// Flow: channel sample -> stage-1 sum register -> saturate/slice -> small FIFO -> registered decoder output.
// Frame length is checked on the input side. Data passes through unchanged on a length error.
module pc_3gpp_llr_map #(
    parameter int pDAT_W   = 16,
    parameter int pLLR_W   = 4,
    parameter int pN_MAX   = 1024,
    parameter int pFIFO_AW = 4,
    parameter int pBPSK    = 0
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  logic              isop,
    input  logic              ieop,
    input  logic              ival,
    input  logic [pDAT_W-1:0] idat_re,
    input  logic [pDAT_W-1:0] idat_im,
    output logic              ordy,
    input  logic              idec_rdy,
    output logic              osop,
    output logic              oeop,
    output logic              oval,
    output logic [pLLR_W-1:0] oLLR,
    output logic              olen_err,
    output logic              oovf
);

    localparam int DEPTH = 2**pFIFO_AW;
    localparam int FW    = pLLR_W + 2;

    // Saturation thresholds on the 12-bit magnitude range (reference 1024).
    localparam logic signed [pDAT_W:0]     SAT_HI   = (pDAT_W+1)'(2047);
    localparam logic signed [pDAT_W:0]     SAT_LO   = (pDAT_W+1)'(-2047);
    localparam logic [pFIFO_AW+1:0]        ORDY_MAX = (pFIFO_AW+2)'(DEPTH - 3);
    localparam logic [pFIFO_AW:0]          FULL_LVL = (pFIFO_AW+1)'(DEPTH);
    localparam logic [10:0]                N_MAX    = 11'(pN_MAX);

    // stage 1
    logic                     s1_val, s1_sop, s1_eop;
    logic signed [pDAT_W:0]   s1_sum;
    logic signed [pDAT_W:0]   sum_in;
    logic [pLLR_W-1:0]        llr;

    // fifo
    logic [FW-1:0]            mem [DEPTH];
    logic [pFIFO_AW-1:0]      wptr, rptr;
    logic [pFIFO_AW:0]        used, used_nxt;
    logic [pFIFO_AW+1:0]      occ_nxt;
    logic                     full, empty, pop, wr, drop, s1_val_nxt;

    // frame counter
    logic [10:0]              cnt, cnt_inc;
    logic                     in_frame;

    // Channel sum: the imaginary branch is ignored in BPSK mode.
    always_comb begin
        sum_in = {idat_re[pDAT_W-1], idat_re};
        if (pBPSK == 0)
            sum_in = sum_in + {idat_im[pDAT_W-1], idat_im};
    end

    // Stage 1: register the sum and the strobes of the accepted sample.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            s1_val <= 1'b0;
            s1_sop <= 1'b0;
            s1_eop <= 1'b0;
            s1_sum <= '0;
        end else if (iclkena) begin
            s1_val <= ival;
            s1_sop <= ival & isop;
            s1_eop <= ival & ieop;
            if (ival)
                s1_sum <= sum_in;
        end
    end

    // Stage 2: saturate out-of-range sums, otherwise slice the top bits.
    // The slice truncates toward minus infinity.
    always_comb begin
        if (s1_sum > SAT_HI)
            llr = {1'b0, {(pLLR_W-1){1'b1}}};
        else if (s1_sum < SAT_LO)
            llr = {1'b1, {(pLLR_W-1){1'b0}}};
        else
            llr = s1_sum[11 -: pLLR_W];
    end

    // FIFO control. A pop frees the head slot, so a write into a full FIFO with a pop succeeds.
    // There is no bypass, so every word is popped at least one cycle after it is written.
    always_comb begin
        full       = (used == FULL_LVL);
        empty      = (used == '0);
        pop        = iclkena & idec_rdy & ~empty;
        wr         = iclkena & s1_val & (~full | pop);
        drop       = iclkena & s1_val & full & ~pop;
        used_nxt   = used + {{pFIFO_AW{1'b0}}, wr} - {{pFIFO_AW{1'b0}}, pop};
        s1_val_nxt = iclkena ? ival : s1_val;
        occ_nxt    = {1'b0, used_nxt} + {{(pFIFO_AW+1){1'b0}}, s1_val_nxt};
    end

    // FIFO storage. It has no reset: the contents only matter behind the pointers.
    always_ff @(posedge iclk) begin
        if (wr)
            mem[wptr] <= {s1_sop, s1_eop, llr};
    end

    // FIFO pointers and fill level, sticky overflow, and ready derived from the next occupancy.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
            oovf <= 1'b0;
            ordy <= 1'b0;
        end else if (iclkena) begin
            if (wr)   wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (drop) oovf <= 1'b1;
            used <= used_nxt;
            ordy <= (occ_nxt <= ORDY_MAX);
        end
    end

    // Decoder output register. Strobes are single-cycle; the LLR holds between pops.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            oval <= 1'b0;
            osop <= 1'b0;
            oeop <= 1'b0;
            oLLR <= '0;
        end else if (iclkena) begin
            oval <= pop;
            if (pop) begin
                {osop, oeop, oLLR} <= mem[rptr];
            end else begin
                osop <= 1'b0;
                oeop <= 1'b0;
            end
        end
    end

    // The count saturates, so an overlong frame cannot wrap back to a valid length.
    always_comb cnt_inc = (&cnt) ? cnt : cnt + 11'd1;

    // Frame length checker on accepted input samples.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            cnt      <= '0;
            in_frame <= 1'b0;
            olen_err <= 1'b0;
        end else if (iclkena) begin
            olen_err <= 1'b0;
            if (ival) begin
                if (isop) begin
                    // a sop inside an open frame restarts the count and is an error
                    cnt      <= 11'd1;
                    in_frame <= ~ieop;
                    olen_err <= in_frame | (ieop & (N_MAX != 11'd1));
                end else if (!in_frame) begin
                    olen_err <= 1'b1;
                end else begin
                    cnt <= cnt_inc;
                    if (ieop) begin
                        in_frame <= 1'b0;
                        olen_err <= (cnt_inc != N_MAX);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_3gpp_llr_map.sv
// Scoreboard bench for pc_3gpp_llr_map.
// Stimulus pushes expected LLRs from an arithmetic model. A negedge monitor pops and compares them.
module tb_pc_3gpp_llr_map;

    localparam int DAT_W = 16;
    localparam int LLR_W = 4;
    localparam int N_MAX = 1024;
    localparam int AW    = 4;
    localparam int DEPTH = 2**AW;

    logic             iclk = 1'b0;
    logic             ireset = 1'b0;
    logic             iclkena = 1'b1;
    logic             isop = 1'b0, ieop = 1'b0, ival = 1'b0;
    logic [DAT_W-1:0] idat_re = '0, idat_im = '0;
    logic             ordy, idec_rdy, osop, oeop, oval, olen_err, oovf;
    logic [LLR_W-1:0] oLLR;

    int rdy_mode = 1;  // 0 = low, 1 = high, 2 = random
    bit rnd_rdy  = 1'b1;
    assign idec_rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? rnd_rdy : 1'b0;

    typedef struct { bit sop; bit eop; int llr; } exp_t;
    exp_t q[$];

    int checks = 0, errors = 0, nout = 0, nerr = 0, ordy_low = 0;

    pc_3gpp_llr_map #(.pDAT_W(DAT_W), .pLLR_W(LLR_W), .pN_MAX(N_MAX),
                      .pFIFO_AW(AW), .pBPSK(0)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .isop(isop), .ieop(ieop), .ival(ival),
        .idat_re(idat_re), .idat_im(idat_im), .ordy(ordy),
        .idec_rdy(idec_rdy), .osop(osop), .oeop(oeop), .oval(oval),
        .oLLR(oLLR), .olen_err(olen_err), .oovf(oovf)
    );

    always #5 iclk = ~iclk;

    always @(negedge iclk) rnd_rdy = ($urandom_range(99) < 70);

    // Reference model: clamp to +/-2047, then floor-divide by 2^(12-W).
    function automatic int model_llr(int re, int im);
        int s, hi;
        s  = re + im;
        hi = (1 << (LLR_W - 1)) - 1;
        if (s > 2047)  return hi;
        if (s < -2047) return -hi - 1;
        return s >>> (12 - LLR_W);
    endfunction

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compare every presented LLR against the head of the expected queue.
    always @(negedge iclk) begin
        exp_t e;
        if (ireset && iclkena) begin
            if (olen_err) nerr++;
            if (!ordy) ordy_low++;
            if (oval) begin
                nout++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected: got llr=%0d sop=%0b eop=%0b, expected no output",
                             $signed(oLLR), osop, oeop);
                end else begin
                    e = q.pop_front();
                    if (osop != e.sop || oeop != e.eop || $signed(oLLR) != e.llr) begin
                        errors++;
                        $display("FAIL out_word: got llr=%0d sop=%0b eop=%0b, expected llr=%0d sop=%0b eop=%0b",
                                 $signed(oLLR), osop, oeop, e.llr, e.sop, e.eop);
                    end
                end
            end
        end
    end

    // Drive one sample starting at a negedge. Returns at the following negedge.
    task automatic drive(bit sop, bit eop, int re, int im, bit respect, bit push);
        exp_t e;
        int t = 0;
        if (respect) begin
            while (!ordy && t < 1000) begin
                @(negedge iclk);
                t++;
            end
            if (t >= 1000) chk("ordy_timeout", 0, 1);
        end
        isop = sop; ieop = eop; ival = 1'b1;
        idat_re = re[DAT_W-1:0];
        idat_im = im[DAT_W-1:0];
        if (push) begin
            e.sop = sop; e.eop = eop; e.llr = model_llr(re, im);
            q.push_back(e);
        end
        @(negedge iclk);
        ival = 1'b0; isop = 1'b0; ieop = 1'b0;
    endtask

    task automatic send_frame(int len, bit with_eop, bit respect);
        for (int i = 0; i < len; i++) begin
            int re = int'($urandom_range(4094)) - 2047;
            int im = int'($urandom_range(4094)) - 2047;
            drive(i == 0, with_eop && (i == len - 1), re, im, respect, 1'b1);
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 5000) begin
            @(negedge iclk);
            t++;
        end
        chk("drain_queue_left", q.size(), 0);
        repeat (4) @(negedge iclk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, o0, lat;
        int re_t[5]  = '{512, -300, 1024, -2047, 2047};
        int im_t[5]  = '{0, -200, 1024, -1, 0};
        int llr_t[5] = '{2, -2, 7, -8, 7};

        // reset state
        repeat (3) @(negedge iclk);
        chk("rst_ordy", ordy, 0);
        chk("rst_oval", oval, 0);
        chk("rst_oovf", oovf, 0);
        chk("rst_olen_err", olen_err, 0);
        chk("rst_oLLR", oLLR, 0);
        ireset = 1'b1;
        @(negedge iclk);
        chk("ordy_after_rst", ordy, 1);

        // single-sample frames: latency and values; each is a length error (1 != N_MAX)
        for (int i = 0; i < 5; i++) begin
            e0 = nerr;
            drive(1'b1, 1'b1, re_t[i], im_t[i], 1'b1, 1'b1);
            lat = 1;
            while (!oval && lat < 8) begin
                @(negedge iclk);
                lat++;
            end
            chk("single_latency", lat, 3);
            chk("single_llr", $signed(oLLR), llr_t[i]);
            repeat (3) @(negedge iclk);
            chk("single_len_err", nerr - e0, 1);
        end

        // full clean frame
        e0 = nerr; o0 = nout;
        send_frame(N_MAX, 1'b1, 1'b1);
        drain();
        chk("full_nout", nout - o0, N_MAX);
        chk("full_len_err", nerr - e0, 0);

        // back-pressure frame
        e0 = nerr; o0 = nout; ordy_low = 0;
        rdy_mode = 2;
        send_frame(N_MAX, 1'b1, 1'b1);
        rdy_mode = 1;
        drain();
        chk("bp_nout", nout - o0, N_MAX);
        chk("bp_oovf", oovf, 0);
        chk("bp_len_err", nerr - e0, 0);
        chk("bp_ordy_dropped", (ordy_low > 0) ? 1 : 0, 1);

        // short frame of 1000: one pulse, one cycle after the eop edge
        e0 = nerr;
        send_frame(1000, 1'b1, 1'b1);
        chk("short_pulse_timing", olen_err, 1);
        drain();
        chk("short_len_err", nerr - e0, 1);

        // sop at sample 500 of an open frame, followed by a clean frame
        e0 = nerr; o0 = nout;
        send_frame(499, 1'b0, 1'b1);
        send_frame(N_MAX, 1'b1, 1'b1);
        drain();
        chk("resop_len_err", nerr - e0, 1);
        chk("resop_nout", nout - o0, 499 + N_MAX);

        // reset in the middle of a frame
        send_frame(300, 1'b0, 1'b1);
        #2;
        ireset = 1'b0;
        #1;
        chk("midrst_oval", oval, 0);
        chk("midrst_osop", osop, 0);
        chk("midrst_oeop", oeop, 0);
        chk("midrst_oLLR", oLLR, 0);
        chk("midrst_ordy", ordy, 0);
        chk("midrst_oovf", oovf, 0);
        q.delete();
        @(negedge iclk);
        ireset = 1'b1;
        @(negedge iclk);
        e0 = nerr; o0 = nout;
        send_frame(N_MAX, 1'b1, 1'b1);
        drain();
        chk("post_rst_nout", nout - o0, N_MAX);
        chk("post_rst_len_err", nerr - e0, 0);

        // overflow: decoder stalled and ready ignored for DEPTH+4 samples
        rdy_mode = 0;
        repeat (2) @(negedge iclk);
        o0 = nout;
        for (int i = 0; i < DEPTH + 4; i++) begin
            int re = int'($urandom_range(4094)) - 2047;
            int im = int'($urandom_range(4094)) - 2047;
            drive(i == 0, 1'b0, re, im, 1'b0, i < DEPTH);
        end
        repeat (2) @(negedge iclk);
        chk("ovf_set", oovf, 1);
        rdy_mode = 1;
        drain();
        repeat (4) @(negedge iclk);
        chk("ovf_nout", nout - o0, DEPTH);
        chk("ovf_sticky", oovf, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
